// File: rtl/dmem_min_scan_ctrl.sv
// Data-memory port sequencer for a hardware signed-minimum search.
// Idle: CPU memory signals pass straight through. Busy: the CPU is stalled and
// locked out while the block scans `count` words, then writes min/index to RES_ADR.
module dmem_min_scan_ctrl #(
  parameter int          CNT_W   = 16,
  parameter logic [31:0] RES_ADR = 32'd2000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [31:0]      base_adr,
  input  logic [CNT_W-1:0] count,
  output logic             busy,
  output logic             done,
  output logic             empty_err,
  output logic [31:0]      min,
  output logic [31:0]      min_idx,
  input  logic [31:0]      cpu_adr,
  input  logic [31:0]      cpu_d_in,
  input  logic             cpu_mrd,
  input  logic             cpu_mwr,
  output logic [31:0]      cpu_d_out,
  output logic             cpu_stall,
  output logic [31:0]      mem_adr,
  output logic [31:0]      mem_d_in,
  output logic             mem_mrd,
  output logic             mem_mwr,
  input  logic [31:0]      mem_d_out
);

  typedef enum logic [2:0] {IDLE, SCAN, WR_MIN, WR_IDX, DONE} state_t;

  state_t           state, nxt;
  logic [31:0]      ptr;
  logic [CNT_W-1:0] remaining;
  logic [CNT_W-1:0] idx;
  logic             first;
  logic [31:0]      run_min;
  logic [CNT_W-1:0] run_idx;
  logic             take;

  // First element always seeds the running min; afterwards only a strictly
  // smaller value replaces it, so ties keep the earliest index.
  assign take = first || ($signed(mem_d_out) < $signed(run_min));

  // State register
  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= nxt;
  end

  // Next state and memory-port mux; CPU pass-through is the default
  always_comb begin
    nxt       = state;
    busy      = 1'b0;
    done      = 1'b0;
    mem_adr   = cpu_adr;
    mem_d_in  = cpu_d_in;
    mem_mrd   = cpu_mrd;
    mem_mwr   = cpu_mwr;
    cpu_d_out = mem_d_out;
    unique case (state)
      IDLE: begin
        if (start) nxt = (count != '0) ? SCAN : DONE;
      end
      SCAN: begin
        busy      = 1'b1;
        mem_adr   = ptr;
        mem_d_in  = 32'd0;
        mem_mrd   = 1'b1;
        mem_mwr   = 1'b0;
        cpu_d_out = 32'd0;
        if (remaining == CNT_W'(1)) nxt = WR_MIN;
      end
      WR_MIN: begin
        busy      = 1'b1;
        mem_adr   = RES_ADR;
        mem_d_in  = run_min;
        mem_mrd   = 1'b0;
        mem_mwr   = 1'b1;
        cpu_d_out = 32'd0;
        nxt       = WR_IDX;
      end
      WR_IDX: begin
        busy      = 1'b1;
        mem_adr   = RES_ADR + 32'd4;
        mem_d_in  = 32'(run_idx);
        mem_mrd   = 1'b0;
        mem_mwr   = 1'b1;
        cpu_d_out = 32'd0;
        nxt       = DONE;
      end
      DONE: begin
        done = 1'b1;
        nxt  = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

  assign cpu_stall = busy;

  // Scan datapath: pointer/index walk, running min, result and error registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      ptr       <= '0;
      remaining <= '0;
      idx       <= '0;
      first     <= 1'b0;
      run_min   <= '0;
      run_idx   <= '0;
      empty_err <= 1'b0;
      min       <= '0;
      min_idx   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            if (count != '0) begin
              ptr       <= base_adr & ~32'h3;
              remaining <= count;
              idx       <= '0;
              first     <= 1'b1;
              empty_err <= 1'b0;
            end else begin
              empty_err <= 1'b1;
            end
          end
        end
        SCAN: begin
          if (take) begin
            run_min <= mem_d_out;
            run_idx <= idx;
          end
          ptr       <= ptr + 32'd4;
          idx       <= idx + CNT_W'(1);
          remaining <= remaining - CNT_W'(1);
          first     <= 1'b0;
        end
        WR_MIN:  min     <= run_min;
        WR_IDX:  min_idx <= 32'(run_idx);
        default: ;
      endcase
    end
  end

endmodule

// File: doc/dmem_min_scan_ctrl.md
Name: dmem_min_scan_ctrl

Overview:
- Sequencer that owns the single data-memory port during a hardware minimum search; sits between the CPU datapath and the data memory.
- On `start` it reads `count` consecutive 32-bit words from `base_adr`, tracks the signed minimum and its element index, then writes both to the result words at RES_ADR and RES_ADR+4.
- While idle, the CPU's memory signals pass straight through. While busy, the CPU is stalled and locked out of memory.

Parameters:
- CNT_W, 16: width of `count` and of the element index counter.
- RES_ADR, 32'd2000: byte address of the result words; min goes to RES_ADR, index to RES_ADR+4.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-low reset, sampled on rising clk.
- start  in  1  level; sampled only in IDLE.
- base_adr  in  32  byte address of element 0; bits [1:0] are ignored and forced to 0.
- count  in  CNT_W  number of elements; sampled with start.
- busy  out  1  high from SCAN through WR_IDX.
- done  out  1  one-cycle pulse in DONE.
- empty_err  out  1  sticky until the next accepted start; set when count==0.
- min  out  32  registered result minimum.
- min_idx  out  32  registered result index, zero-extended.
- cpu_adr  in  32  CPU address.
- cpu_d_in  in  32  CPU write data.
- cpu_mrd  in  1  CPU read enable.
- cpu_mwr  in  1  CPU write enable.
- cpu_d_out  out  32  read data to CPU.
- cpu_stall  out  1  equals busy.
- mem_adr  out  32  to memory adr.
- mem_d_in  out  32  to memory d_in.
- mem_mrd  out  1  to memory mrd.
- mem_mwr  out  1  to memory mwr.
- mem_d_out  in  32  combinational read data from memory. Word is little-endian, bytes adr..adr+3. Memory writes on rising clk when mwr=1.

Behaviour:
Reset (rst=0 at a rising edge):
- State goes to IDLE.
- busy=0, done=0, empty_err=0, min=0, min_idx=0.
- Internal pointer, index and running-min registers are cleared.
- Reset mid-scan aborts immediately. No result write occurs unless WR_MIN/WR_IDX already completed on an earlier edge.

State IDLE:
- mem_* = cpu_* exactly; cpu_d_out = mem_d_out.
- If start=1 and count!=0: latch ptr = {base_adr[31:2],2'b00}, remaining = count, idx = 0, first = 1, clear empty_err; go to SCAN.
- If start=1 and count==0: set empty_err; go to DONE; no memory access; min and min_idx unchanged.

State SCAN:
- One element per cycle: mem_adr = ptr, mem_mrd = 1, mem_mwr = 0.
- On each edge, candidate = mem_d_out. If first, or $signed(candidate) < $signed(run_min): run_min <= candidate and run_idx <= idx.
- Compare is strict, so ties keep the earliest index.
- Each edge: ptr += 4 (mod 2^32 wrap), idx += 1, remaining -= 1, first <= 0.
- When remaining==1 at the edge, go to WR_MIN. SCAN lasts exactly `count` cycles.

State WR_MIN:
- mem_adr = RES_ADR, mem_d_in = run_min, mem_mwr = 1, mem_mrd = 0.
- At the edge, min <= run_min; go to WR_IDX.

State WR_IDX:
- mem_adr = RES_ADR+4, mem_d_in = zero-extended run_idx, mem_mwr = 1.
- At the edge, min_idx <= run_idx; go to DONE.

State DONE:
- done = 1, busy = 0, memory bus back on CPU pass-through.
- start is ignored in this cycle. Next state is IDLE.

While busy:
- cpu_stall = 1, cpu_d_out = 0, and cpu_mwr/cpu_mrd are not forwarded (CPU writes are dropped).
- start is ignored.

Latency:
- start accepted at edge T.
- busy=1 for count+2 cycles after T.
- done is high in cycle T+count+3.
- Earliest next accepted start is at the edge ending the DONE cycle + 1 (i.e. when back in IDLE).

Test Plan:
- Pass-through: in IDLE, CPU writes 0x12345678 at adr 100, then reads adr 100 -> cpu_d_out=0x12345678; busy=0.
- Basic scan: words at 1000..1012 = 5, -3, 7, -3; start with base 1000, count 4 -> busy for 6 cycles; mem[2000]=0xFFFFFFFD, mem[2004]=1; done pulses once at cycle 7; min=-3, min_idx=1.
- Signed/unaligned: base 1002 (treated as 1000), words 0x7FFFFFFF, 0x80000000, count 2 -> min=0x80000000, min_idx=1.
- Single and empty: count 1 with word 42 -> min=42, idx=0, busy 3 cycles. Then count 0 -> empty_err=1, done after 1 cycle, no mem_mwr, min stays 42.
- Lockout: during scan, CPU asserts mwr to 1004 with 0 -> memory unchanged, cpu_stall=1, cpu_d_out=0. A second start while busy is ignored, so only one done pulse occurs.
- Reset abort: rst=0 during the 2nd SCAN cycle of a count-4 scan -> next cycle IDLE, all outputs 0, mem[2000] and mem[2004] retain their prior values.
